// File: rtl/regfile_pkg.sv
// Shared constants and types for the general-purpose register file.
// Default widths match the MIPS integer register set.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NUM_RD_DEF = 3;

    typedef logic [DATA_W_DEF-1:0] reg_data_t;
    typedef logic [ADDR_W_DEF-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_bypass_mux.sv
// One read port: stored value, same-cycle writeback bypass and busy view.
// The load port (wr1) wins over the ALU port (wr0); r0 override wins over both.
module regfile_bypass_mux
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              hold_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] stored,
    input  logic              busy_bit,
    input  logic              wr0_en,
    input  logic [ADDR_W-1:0] wr0_addr,
    input  logic [DATA_W-1:0] wr0_data,
    input  logic              wr1_en,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic [DATA_W-1:0] wr1_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_busy
);

    logic hit0;
    logic hit1;
    logic is_zero;

    // Match the read index against both writeback ports and the zero register
    always_comb begin
        hit0    = wr0_en && (wr0_addr == addr);
        hit1    = wr1_en && (wr1_addr == addr);
        is_zero = ZERO_REG && (addr == '0);
    end

    // Select read data; reset hold and r0 force zero ahead of any bypass
    always_comb begin
        rd_data = stored;
        if (!hold_n || is_zero) begin
            rd_data = '0;
        end else if (hit1) begin
            rd_data = wr1_data;
        end else if (hit0) begin
            rd_data = wr0_data;
        end
    end

    // Busy as seen by decode: a producer writing back this cycle is done
    always_comb begin
        rd_busy = hold_n && !is_zero && busy_bit && !(hit0 || hit1);
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with dual writeback and per-register busy scoreboard.
// Decode reads and issues here; writeback clears busy and bypasses into reads.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = NUM_RD_DEF,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr0_en,
    input  logic [ADDR_W-1:0]        wr0_addr,
    input  logic [DATA_W-1:0]        wr0_data,
    input  logic                     wr1_en,
    input  logic [ADDR_W-1:0]        wr1_addr,
    input  logic [DATA_W-1:0]        wr1_data,
    input  logic                     issue_en,
    input  logic [ADDR_W-1:0]        issue_addr,
    output logic                     issue_ready,
    input  logic                     flush,
    output logic                     err_reissue
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic              err_q;
    logic              w0_ok;
    logic              w1_ok;
    logic              iss_ok;

    // Qualify writes and issues; r0 is inert when hardwired to zero
    always_comb begin
        w0_ok  = wr0_en && !(ZERO_REG && (wr0_addr == '0));
        w1_ok  = wr1_en && !(ZERO_REG && (wr1_addr == '0));
        iss_ok = issue_en && !(ZERO_REG && (issue_addr == '0));
    end

    // Next busy vector: flush, then writeback clears, then a new issue sets
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < DEPTH; i++) begin
            busy_d[i] = busy_q[i] & ~flush;
            if (w0_ok && (wr0_addr == ADDR_W'(i))) begin
                busy_d[i] = 1'b0;
            end
            if (w1_ok && (wr1_addr == ADDR_W'(i))) begin
                busy_d[i] = 1'b0;
            end
            if (iss_ok && (issue_addr == ADDR_W'(i))) begin
                busy_d[i] = 1'b1;
            end
        end
        if (ZERO_REG) begin
            busy_d[0] = 1'b0;
        end
    end

    // Register storage; the load port lands last so it wins a collision
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (w0_ok) begin
                regs[wr0_addr] <= wr0_data;
            end
            if (w1_ok) begin
                regs[wr1_addr] <= wr1_data;
            end
        end
    end

    // Busy scoreboard state
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Issue is allowed only when the destination has no pending producer
    always_comb begin
        issue_ready = ~busy_q[issue_addr];
    end

    // Sticky flag for an issue attempted against a busy destination
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else if (issue_en && !issue_ready) begin
            err_q <= 1'b1;
        end
    end

    assign err_reissue = err_q;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] a;

        assign a = rd_addr[k*ADDR_W +: ADDR_W];

        regfile_bypass_mux #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG)
        ) u_mux (
            .hold_n   (reset_n),
            .addr     (a),
            .stored   (regs[a]),
            .busy_bit (busy_q[a]),
            .wr0_en   (wr0_en),
            .wr0_addr (wr0_addr),
            .wr0_data (wr0_data),
            .wr1_en   (wr1_en),
            .wr1_addr (wr1_addr),
            .wr1_data (wr1_data),
            .rd_data  (rd_data[k*DATA_W +: DATA_W]),
            .rd_busy  (rd_busy[k])
        );
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed scenarios plus random traffic
// checked against an array-based model of the register file.
module tb_regfile_scoreboard;
    import regfile_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 3;
    localparam int DEPTH = 32;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*DW-1:0]  rd_data;
    logic [NR-1:0]     rd_busy;
    logic              wr0_en;
    reg_idx_t          wr0_addr;
    reg_data_t         wr0_data;
    logic              wr1_en;
    reg_idx_t          wr1_addr;
    reg_data_t         wr1_data;
    logic              issue_en;
    reg_idx_t          issue_addr;
    logic              issue_ready;
    logic              flush;
    logic              err_reissue;

    logic [DW-1:0] m_regs [DEPTH];
    logic          m_busy [DEPTH];
    logic          m_err;

    int n_chk = 0;
    int n_err = 0;

    regfile_scoreboard #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .NUM_RD   (NR),
        .ZERO_REG (1'b1)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_busy     (rd_busy),
        .wr0_en      (wr0_en),
        .wr0_addr    (wr0_addr),
        .wr0_data    (wr0_data),
        .wr1_en      (wr1_en),
        .wr1_addr    (wr1_addr),
        .wr1_data    (wr1_data),
        .issue_en    (issue_en),
        .issue_addr  (issue_addr),
        .issue_ready (issue_ready),
        .flush       (flush),
        .err_reissue (err_reissue)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rdk(input int k);
        return rd_data[k*DW +: DW];
    endfunction

    task automatic set_rd(input int k, input reg_idx_t a);
        rd_addr[k*AW +: AW] = a;
    endtask

    task automatic idle();
        wr0_en   = 1'b0;
        wr1_en   = 1'b0;
        issue_en = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
        m_err = 1'b0;
    endtask

    // Architectural effect of one clock edge with the current inputs
    task automatic model_edge();
        if (!reset_n) return;
        if (issue_en && m_busy[issue_addr]) m_err = 1'b1;
        if (wr0_en && wr0_addr != 0) m_regs[wr0_addr] = wr0_data;
        if (wr1_en && wr1_addr != 0) m_regs[wr1_addr] = wr1_data;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
        end
        if (wr0_en) m_busy[wr0_addr] = 1'b0;
        if (wr1_en) m_busy[wr1_addr] = 1'b0;
        if (issue_en && issue_addr != 0) m_busy[issue_addr] = 1'b1;
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < NR; k++) begin
            reg_idx_t  a;
            logic      hit0, hit1;
            reg_data_t ed;
            logic      eb;
            a    = rd_addr[k*AW +: AW];
            hit0 = wr0_en && wr0_addr == a;
            hit1 = wr1_en && wr1_addr == a;
            if (!reset_n || a == 0) ed = '0;
            else if (hit1) ed = wr1_data;
            else if (hit0) ed = wr0_data;
            else ed = m_regs[a];
            eb = reset_n && m_busy[a] && !(hit0 || hit1);
            check($sformatf("%s rd%0d data", tag, k), 64'(rdk(k)), 64'(ed));
            check($sformatf("%s rd%0d busy", tag, k), 64'(rd_busy[k]), 64'(eb));
        end
        check({tag, " ready"}, 64'(issue_ready), 64'(!m_busy[issue_addr]));
        check({tag, " err"}, 64'(err_reissue), 64'(m_err));
    endtask

    task automatic cycle(input string tag);
        #2;
        check_all(tag);
        @(posedge clock);
        model_edge();
        #1;
    endtask

    function automatic reg_idx_t pick();
        if ($urandom_range(0, 3) == 0) return reg_idx_t'($urandom);
        return reg_idx_t'($urandom_range(0, 7));
    endfunction

    initial begin
        idle();
        rd_addr    = '0;
        wr0_addr   = '0;
        wr0_data   = '0;
        wr1_addr   = '0;
        wr1_data   = '0;
        issue_addr = '0;
        model_reset();

        set_rd(0, 5);
        set_rd(1, 3);
        set_rd(2, 7);
        wr1_en   = 1'b1;
        wr1_addr = 5;
        wr1_data = 32'h1234_5678;
        #1;
        check("reset rd0", 64'(rdk(0)), 64'h0);
        check("reset ready", 64'(issue_ready), 64'h1);
        check("reset err", 64'(err_reissue), 64'h0);
        cycle("rst");
        reset_n = 1'b1;
        idle();

        // Reset mid-run clears stored data immediately
        wr0_en   = 1'b1;
        wr0_addr = 5;
        wr0_data = 32'hDEAD_BEEF;
        cycle("t1w");
        idle();
        set_rd(0, 5);
        #1;
        check("t1 stored", 64'(rdk(0)), 64'hDEAD_BEEF);
        reset_n = 1'b0;
        model_reset();
        #1;
        check("t1 async", 64'(rdk(0)), 64'h0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Same-cycle bypass then stored value
        wr0_en   = 1'b1;
        wr0_addr = 3;
        wr0_data = 32'h11;
        set_rd(0, 3);
        #1;
        check("t2 bypass", 64'(rdk(0)), 64'h11);
        cycle("t2a");
        idle();
        #1;
        check("t2 stored", 64'(rdk(0)), 64'h11);
        cycle("t2b");

        // Write port collision: load port wins
        wr0_en   = 1'b1;
        wr0_addr = 7;
        wr0_data = 32'hAAAA;
        wr1_en   = 1'b1;
        wr1_addr = 7;
        wr1_data = 32'h5555;
        set_rd(0, 7);
        #1;
        check("t3 bypass", 64'(rdk(0)), 64'h5555);
        cycle("t3a");
        idle();
        #1;
        check("t3 stored", 64'(rdk(0)), 64'h5555);
        cycle("t3b");

        // Register zero ignores writes and issues
        wr1_en     = 1'b1;
        wr1_addr   = 0;
        wr1_data   = 32'hFFFF_FFFF;
        issue_en   = 1'b1;
        issue_addr = 0;
        set_rd(0, 0);
        #1;
        check("t4 r0 byp", 64'(rdk(0)), 64'h0);
        cycle("t4a");
        idle();
        #1;
        check("t4 r0", 64'(rdk(0)), 64'h0);
        check("t4 ready", 64'(issue_ready), 64'h1);
        check("t4 err", 64'(err_reissue), 64'h0);
        cycle("t4b");

        // Scoreboard set / clear / new-producer-wins / sticky error
        issue_en   = 1'b1;
        issue_addr = 9;
        cycle("t5i");
        idle();
        set_rd(0, 9);
        #1;
        check("t5 ready0", 64'(issue_ready), 64'h0);
        check("t5 busy", 64'(rd_busy[0]), 64'h1);
        cycle("t5a");
        wr0_en   = 1'b1;
        wr0_addr = 9;
        wr0_data = 32'h99;
        cycle("t5w");
        idle();
        #1;
        check("t5 ready1", 64'(issue_ready), 64'h1);
        issue_en = 1'b1;
        wr1_en   = 1'b1;
        wr1_addr = 9;
        wr1_data = 32'h77;
        cycle("t5iw");
        idle();
        #1;
        check("t5 iw busy", 64'(issue_ready), 64'h0);
        check("t5 no err", 64'(err_reissue), 64'h0);
        issue_en = 1'b1;
        cycle("t5re");
        idle();
        cycle("t5h1");
        cycle("t5h2");
        #1;
        check("t5 sticky", 64'(err_reissue), 64'h1);

        // Flush clears everything except the same-cycle issue
        wr0_en     = 1'b1;
        wr0_addr   = 2;
        wr0_data   = 32'h22;
        wr1_en     = 1'b1;
        wr1_addr   = 4;
        wr1_data   = 32'h44;
        issue_en   = 1'b1;
        issue_addr = 2;
        cycle("t6w");
        idle();
        issue_en   = 1'b1;
        issue_addr = 4;
        cycle("t6i");
        idle();
        flush      = 1'b1;
        issue_en   = 1'b1;
        issue_addr = 6;
        cycle("t6f");
        idle();
        set_rd(0, 2);
        set_rd(1, 4);
        set_rd(2, 6);
        #1;
        check("t6 r2 busy", 64'(rd_busy[0]), 64'h0);
        check("t6 r4 busy", 64'(rd_busy[1]), 64'h0);
        check("t6 r6 busy", 64'(rd_busy[2]), 64'h1);
        check("t6 r2 data", 64'(rdk(0)), 64'h22);
        check("t6 r4 data", 64'(rdk(1)), 64'h44);
        cycle("t6c");

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            wr0_en     = $urandom_range(0, 1) == 1;
            wr0_addr   = pick();
            wr0_data   = $urandom;
            wr1_en     = $urandom_range(0, 2) == 0;
            wr1_addr   = pick();
            wr1_data   = $urandom;
            issue_en   = $urandom_range(0, 3) == 0;
            issue_addr = pick();
            flush      = $urandom_range(0, 15) == 0;
            for (int k = 0; k < NR; k++) set_rd(k, pick());
            if (n == 1500) begin
                reset_n = 1'b0;
                model_reset();
                cycle("rndrst");
                reset_n = 1'b1;
            end else begin
                cycle("rnd");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
